// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame constants and bit-period math.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte queue for the UART transmitter; push is refused when full, pop when empty, 1-cycle write-to-read.
// Flags and count come straight from registers so full/empty never depend on same-cycle push/pop.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with byte FIFO; start bit appears 2 cycles after a byte enters an idle block.
// tx_ready drops only when the FIFO is full; frames queued back-to-back are sent with no idle gap.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(CPB + 1);
    localparam int BW  = $clog2(DATA_BITS);

    uart_state_e          state_q;
    logic [CW-1:0]        baud_cnt_q;
    logic [BW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 txd_q;
    logic                 line_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [7:0]           fifo_rdata;
    logic                 bit_done;
    logic                 data_last;
    logic                 stop_last;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (tx_valid),
        .wdata_i (tx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bit_done  = (baud_cnt_q == CW'(CPB - 1));
    assign data_last = (bit_idx_q == BW'(DATA_BITS - 1));
    assign stop_last = (bit_idx_q == BW'(STOP_BITS - 1));

    // Pop exactly where the FSM loads the shift register: in IDLE, or at the last stop-bit edge.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == IDLE) || ((state_q == STOP) && bit_done && stop_last));

    always_comb begin
        line_d = 1'b1;
        case (state_q)
            START:   line_d = 1'b0;
            DATA:    line_d = shift_q[0];
            default: line_d = 1'b1;
        endcase
    end

    // The line flop follows the state one cycle later, giving a glitch-free pin and uniform bit lengths.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            txd_q <= line_d;
            case (state_q)
                IDLE: begin
                    baud_cnt_q <= '0;
                    bit_idx_q  <= '0;
                    if (fifo_pop) begin
                        shift_q <= fifo_rdata;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        state_q    <= DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        shift_q    <= {1'b0, shift_q[DATA_BITS-1:1]};
                        if (data_last) begin
                            bit_idx_q <= '0;
                            state_q   <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + BW'(1);
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        if (stop_last) begin
                            bit_idx_q <= '0;
                            if (fifo_pop) begin
                                shift_q <= fifo_rdata;
                                state_q <= START;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + BW'(1);
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uart_txd = txd_q;
    assign tx_ready = !fifo_full;
    assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-schedule reference model, per-cycle output compare and line decoder.
module tb_uart_transmitter;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 58_000;
    localparam int DEPTH    = 16;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * CPB;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [7:0]               tx_data = 8'h00;
    logic                     tx_valid = 1'b0;
    logic                     tx_ready;
    logic                     uart_txd;
    logic                     busy;
    logic [$clog2(DEPTH):0]   fifo_count;

    uart_transmitter #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_txd   (uart_txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Reference model: each accepted byte gets a frame start edge = max(accept+2, end of previous frame).
    int         n         = 0;
    logic [7:0] fr_data[$];
    int         fr_start[$];
    int         pop_idx   = 0;
    int         line_idx  = 0;
    int         last_end  = 0;
    bit         acc_flag  = 0;
    int         acc_edge  = 0;
    bit         exp_txd   = 1;
    bit         exp_busy  = 0;
    bit         exp_ready = 1;
    int         exp_count = 0;

    always @(posedge clk or negedge reset_n) begin : model
        int s;
        int bitn;
        if (!reset_n) begin
            n = 0; fr_data.delete(); fr_start.delete();
            pop_idx = 0; line_idx = 0; last_end = 0; acc_flag = 0;
            exp_txd = 1; exp_busy = 0; exp_ready = 1; exp_count = 0;
        end else begin
            n = n + 1;
            acc_flag = 0;
            if (tx_valid && exp_ready) begin
                s = (n + 2 > last_end) ? n + 2 : last_end;
                fr_data.push_back(tx_data);
                fr_start.push_back(s);
                last_end = s + FRAME;
                acc_flag = 1;
                acc_edge = n;
            end
            while (pop_idx < fr_start.size() && fr_start[pop_idx] - 1 <= n) pop_idx++;
            exp_count = fr_start.size() - pop_idx;
            exp_ready = (exp_count < DEPTH);
            while (line_idx < fr_start.size() && fr_start[line_idx] + FRAME <= n) line_idx++;
            exp_txd = 1;
            if (line_idx < fr_start.size() && fr_start[line_idx] <= n) begin
                bitn = (n - fr_start[line_idx]) / CPB;
                if (bitn == 0) exp_txd = 0;
                else if (bitn <= 8) exp_txd = fr_data[line_idx][bitn-1];
            end
            exp_busy = (exp_count != 0) ||
                       (pop_idx > 0 && n <= fr_start[pop_idx-1] + FRAME - 2);
        end
    end

    // Compare process: outputs every cycle, plus a mid-bit line decoder checking each frame in order.
    bit         chk_en  = 0;
    bit         rx_busy = 0;
    int         rx_cnt  = 0;
    int         rx_idx  = 0;
    logic [9:0] rx_bits = '0;

    always @(negedge clk) begin : compare
        int k;
        if (!reset_n) begin
            rx_busy = 0; rx_cnt = 0; rx_idx = 0;
        end else if (chk_en) begin
            check("txd", int'(uart_txd), int'(exp_txd));
            check("tx_ready", int'(tx_ready), int'(exp_ready));
            check("busy", int'(busy), int'(exp_busy));
            check("fifo_count", int'(fifo_count), exp_count);
            if (!rx_busy && uart_txd == 1'b0) begin
                rx_busy = 1; rx_cnt = 0;
            end
            if (rx_busy) begin
                if (rx_cnt % CPB == CPB / 2) begin
                    k = rx_cnt / CPB;
                    rx_bits[k] = uart_txd;
                    if (k == 9) begin
                        check("rx_framing", int'({rx_bits[9], rx_bits[0]}), 2);
                        if (rx_idx < fr_data.size())
                            check("rx_byte", int'(rx_bits[8:1]), int'(fr_data[rx_idx]));
                        else
                            check("rx_extra_frame", rx_idx, fr_data.size() - 1);
                        rx_idx++;
                        rx_busy = 0;
                    end
                end
                rx_cnt++;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bit ok = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (acc_flag) begin ok = 1; break; end
        end
        tx_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!exp_busy && !rx_busy) begin ok = 1; break; end
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    // Finds the start-bit fall, then samples nbits bit centres; low = length of the initial low run.
    task automatic grab(input int nbits, output int fall, output int low, output logic [0:29] bits);
        int  off;
        bit  rose = 0;
        fall = -1; low = 0; bits = '0;
        for (int i = 0; i < 100 && fall < 0; i++) begin
            if (!uart_txd) fall = n;
            else @(negedge clk);
        end
        if (fall < 0) begin
            check("start_bit_timeout", 0, 1);
            return;
        end
        while (n < fall + nbits * CPB) begin
            off = n - fall;
            if (off % CPB == CPB / 2) bits[off / CPB] = uart_txd;
            if (!rose) begin
                if (!uart_txd) low++;
                else rose = 1;
            end
            @(negedge clk);
        end
    endtask

    logic [0:29] bits;
    logic [0:9]  exp_55  = 10'b0101010101;
    logic [0:7]  exp_a3  = 8'b11000101;
    logic [0:29] exp_b2b = 30'b0100000001_0010000001_0110000001;
    int          fall, low, first_acc, nacc, rx_base, zeros, accepted, guard, s0;

    initial begin
        reset_n = 1'b0;
        @(negedge clk);
        check("reset_txd", int'(uart_txd), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_tx_ready", int'(tx_ready), 1);
        check("reset_fifo_count", int'(fifo_count), 0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        chk_en = 1;
        repeat (3) @(negedge clk);

        // Single byte 0x55
        send(8'h55);
        first_acc = acc_edge;
        grab(10, fall, low, bits);
        check("start_latency", fall - first_acc, 2);
        check("start_bit_cycles", low, 17);
        check("frame_0x55", int'(bits[0:9]), int'(exp_55));
        wait_idle();
        check("busy_after_frame", int'(busy), 0);

        // Bit order 0xA3
        send(8'hA3);
        grab(10, fall, low, bits);
        check("a3_start", int'(bits[0]), 0);
        check("a3_data", int'(bits[1:8]), int'(exp_a3));
        check("a3_stop", int'(bits[9]), 1);
        wait_idle();

        // Back-to-back 0x01,0x02,0x03 on consecutive cycles
        nacc = 0;
        tx_valid = 1'b1; tx_data = 8'h01;
        @(negedge clk); if (acc_flag) nacc++; first_acc = acc_edge; tx_data = 8'h02;
        @(negedge clk); if (acc_flag) nacc++; tx_data = 8'h03;
        @(negedge clk); if (acc_flag) nacc++; tx_valid = 1'b0;
        check("b2b_accepted", nacc, 3);
        grab(30, fall, low, bits);
        check("b2b_latency", fall - first_acc, 2);
        check("b2b_30_bits", int'(bits), int'(exp_b2b));
        wait_idle();

        // Full FIFO with tx_valid held and incrementing data
        rx_base = rx_idx;
        nacc = 0;
        tx_data = 8'h00; tx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (acc_flag) begin nacc++; tx_data = tx_data + 8'd1; end
            if (!tx_ready) break;
        end
        check("full_accepted", nacc, DEPTH + 1);
        repeat (40) begin
            @(negedge clk);
            if (acc_flag) nacc++;
        end
        tx_valid = 1'b0;
        check("full_no_extra", nacc, DEPTH + 1);
        wait_idle();
        check("full_rx_frames", rx_idx - rx_base, DEPTH + 1);

        // Reset during data bit 4 with one byte still queued
        send(8'hEF);
        send(8'h3C);
        s0 = fr_start[fr_start.size() - 2];
        while (n < s0 + 5 * CPB + CPB / 2) @(negedge clk);
        check("pre_reset_txd", int'(uart_txd), 0);
        check("pre_reset_count", int'(fifo_count), 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_reset_txd", int'(uart_txd), 1);
        check("mid_reset_count", int'(fifo_count), 0);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_ready", int'(tx_ready), 1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        zeros = 0;
        repeat (300) begin
            @(negedge clk);
            if (!uart_txd) zeros++;
        end
        check("idle_after_reset", zeros, 0);

        // Random traffic: 256 bytes with random valid gaps and occasional drains
        accepted = 0; guard = 0;
        tx_data = 8'($urandom_range(0, 255));
        tx_valid = 1'b1;
        while (accepted < 256 && guard < 60000) begin
            @(negedge clk);
            guard++;
            if (acc_flag) begin
                accepted++;
                tx_data = 8'($urandom_range(0, 255));
                if (accepted % 40 == 0) begin
                    tx_valid = 1'b0;
                    wait_idle();
                end
            end
            tx_valid = ($urandom_range(0, 7) != 0) && (accepted < 256);
        end
        tx_valid = 1'b0;
        check("rand_accepted", accepted, 256);
        wait_idle();
        check("rand_rx_frames", rx_idx, 256);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000: input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200: line bit rate.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16 (power of two, at least 2): number of pending bytes.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, 50 MHz on board; all logic on the rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port tx_data, input, 8 bits: byte to send.
REQ-007 The block SHALL have port tx_valid, input, 1 bit: tx_data is valid this cycle.
REQ-008 The block SHALL have port tx_ready, output, 1 bit: the block can accept a byte.
REQ-009 The block SHALL have port uart_txd, output, 1 bit: serial line, driven to the board UART_TXD pin.
REQ-010 The block SHALL have port busy, output, 1 bit: a frame is in progress or bytes are queued.
REQ-011 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of queued bytes, excluding the byte being shifted.

Function
REQ-012 Line format SHALL be 8N1: one start bit (0), eight data bits sent LSB first, one stop bit (1), no parity.
REQ-013 Bit period SHALL be CLKS_PER_BIT = floor(CLK_FREQ/BAUD) clk cycles (434 at the defaults); every bit, start and stop included, lasts exactly that long.
REQ-014 A byte SHALL be accepted on a rising edge where tx_valid and tx_ready are both 1; a byte offered while tx_ready is 0 is ignored and not queued.
REQ-015 tx_ready SHALL equal NOT full, decoded from registered FIFO state only, with no combinational path from the transmit-side pop.
REQ-016 A simultaneous push and pop on a full FIFO SHALL NOT accept the push.
REQ-017 A simultaneous push and pop on a non-full FIFO SHALL accept the push and leave fifo_count unchanged.
REQ-018 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-019 IDLE: uart_txd SHALL be 1; when the FIFO is non-empty, the block SHALL pop one byte into the shift register and enter START on the next edge.
REQ-020 START: uart_txd SHALL be 0 for CLKS_PER_BIT cycles, then the FSM SHALL enter DATA.
REQ-021 DATA: uart_txd SHALL be shift[0]; after each bit period the register shifts right and the bit index increments; after bit index 7 the FSM SHALL enter STOP.
REQ-022 STOP: uart_txd SHALL be 1 for CLKS_PER_BIT cycles.
REQ-023 At the end of STOP, if the FIFO is non-empty the block SHALL pop the next byte and enter START directly, with no idle gap; otherwise it SHALL enter IDLE.
REQ-024 Latency from a byte accepted into an empty FIFO in IDLE to the start-bit falling edge on uart_txd SHALL be 2 clk cycles.
REQ-025 uart_txd SHALL come from a flip-flop, to avoid glitches.
REQ-026 The baud counter SHALL reset to 0 at each bit boundary, so no drift accumulates across frames.
REQ-027 busy SHALL be 1 when the state is not IDLE or fifo_count is not 0.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 FIFO full SHALL be fifo_count == FIFO_DEPTH; empty SHALL be fifo_count == 0.

Reset
REQ-030 While reset_n is 0, the block SHALL hold: uart_txd = 1, state = IDLE, baud counter = 0, bit index = 0, FIFO pointers and fifo_count = 0, busy = 0, tx_ready = 1.
REQ-031 Assertion of reset_n mid-frame SHALL force uart_txd to 1 immediately (asynchronously), discard the frame in progress and all queued bytes, and leave no partial frame on release.

Structure
REQ-032 A shared package uart_pkg SHALL hold the state enum (IDLE, START, DATA, STOP), the constants DATA_BITS = 8 and STOP_BITS = 1, and the CLKS_PER_BIT calculation, for reuse by uart_receiver.
REQ-033 The FIFO SHALL be one sub-module, uart_tx_fifo, with synchronous push/pop, asynchronous active-low reset, and outputs full, empty and count.
REQ-034 The FSM, baud counter and shift register SHALL sit in uart_transmitter.

Verification
REQ-035 Scenario, single byte: send 0x55 in IDLE -> start edge at +2 cycles; line reads 0,1,0,1,0,1,0,1,0,1 with each bit 434 cycles; busy then drops to 0.
REQ-036 Scenario, bit order: send 0xA3 -> data bits on the line are 1,1,0,0,0,1,0,1 (LSB first); stop bit = 1.
REQ-037 Scenario, back-to-back: send 0x01, 0x02, 0x03 on consecutive cycles -> 30 contiguous bit periods (13020 cycles), no idle gap between frames.
REQ-038 Scenario, full FIFO: hold tx_valid with incrementing data -> exactly FIFO_DEPTH+1 (17) bytes accepted before tx_ready goes 0; all 17 bytes are transmitted in order with none lost or duplicated.
REQ-039 Scenario, reset mid-frame: pulse reset_n low during DATA bit 4 -> uart_txd = 1 within the same cycle; fifo_count = 0; after release the line stays idle until a new write.
REQ-040 Scenario, loopback: uart_txd wired to uart_receiver rx_data; 256 random bytes sent -> every data_out matches in order, with data_valid pulsed once per byte.
